// File: rtl/sram_array_1r1w.sv
// sram_array_1r1w: 1R1W SRAM array with post-reset clear, write masks and held registered read.
// Optional SRAM_BYPASS_EN forwards same-address write segments into the read result.
module sram_array_1r1w #(
   parameter int DEPTH = 64,
   parameter int WIDTH = 25,
   parameter int MASK_SEGS = 1,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic                 clock,
   input  logic                 reset_n,
   output logic                 ready,
   input  logic                 R0_en,
   input  logic [AW-1:0]        R0_addr,
   output logic [WIDTH-1:0]     R0_data,
   output logic                 R0_valid,
   input  logic                 W0_en,
   input  logic [AW-1:0]        W0_addr,
   input  logic [WIDTH-1:0]     W0_data,
   input  logic [MASK_SEGS-1:0] W0_mask
);
   localparam int G = WIDTH / MASK_SEGS;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   typedef enum logic {CLEAR, READY} state_t;
   state_t state, state_nxt;
   logic [AW-1:0] clr_idx, clr_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_word, wr_word;
   logic rd_acc, wr_acc, r_ok, w_ok;
   assign ready = state == READY;
   assign rd_acc = ready && R0_en;
   assign wr_acc = ready && W0_en;
   assign r_ok = {1'b0, R0_addr} < (AW+1)'(DEPTH);
   assign w_ok = {1'b0, W0_addr} < (AW+1)'(DEPTH);
   always_comb begin
      state_nxt = (state == CLEAR && clr_idx == LAST) ? READY : state;
      clr_nxt = (state == CLEAR) ? clr_idx + AW'(1) : clr_idx;
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= CLEAR;
         clr_idx <= '0;
      end else begin
         state <= state_nxt;
         clr_idx <= clr_nxt;
      end
   end
   // Merged write word doubles as the forwarded read word in bypass builds
   always_comb begin
      wr_word = w_ok ? mem[W0_addr] : '0;
      for (int i = 0; i < MASK_SEGS; i++)
         if (W0_mask[i]) wr_word[i*G +: G] = W0_data[i*G +: G];
      rd_word = r_ok ? mem[R0_addr] : '0;
`ifdef SRAM_BYPASS_EN
      if (wr_acc && w_ok && r_ok && W0_addr == R0_addr) rd_word = wr_word;
`endif
   end
   always_ff @(posedge clock) begin
      if (reset_n) begin
         if (state == CLEAR) mem[clr_idx] <= '0;
         else if (wr_acc && w_ok) mem[W0_addr] <= wr_word;
      end
   end
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         R0_valid <= 1'b0;
         R0_data <= '0;
      end else begin
         R0_valid <= rd_acc;
         if (rd_acc) R0_data <= rd_word;
      end
   end
endmodule

// File: tb/tb_sram_array_1r1w.sv
// tb_sram_array_1r1w: randomized and directed checks of sram_array_1r1w against a behavioural model.
module tb_sram_array_1r1w;
   logic clock = 0;
   always #5 clock = ~clock;
   logic reset_n = 0, ready, r_en = 0, w_en = 0, valid;
   logic [2:0] r_addr = 0, w_addr = 0;
   logic [31:0] data, w_data = 0;
   logic [3:0] w_mask = 0;
   logic b_rst_n = 0, b_ready, b_r_en = 0, b_w_en = 0, b_valid;
   logic [2:0] b_r_addr = 0, b_w_addr = 0;
   logic [7:0] b_data, b_w_data = 0;
   logic [0:0] b_w_mask = 1'b1;
   int checks = 0, failures = 0;

   sram_array_1r1w #(.DEPTH(8), .WIDTH(32), .MASK_SEGS(4)) dut (
      .clock(clock), .reset_n(reset_n), .ready(ready),
      .R0_en(r_en), .R0_addr(r_addr), .R0_data(data), .R0_valid(valid),
      .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask));

   sram_array_1r1w #(.DEPTH(6), .WIDTH(8), .MASK_SEGS(1)) dut6 (
      .clock(clock), .reset_n(b_rst_n), .ready(b_ready),
      .R0_en(b_r_en), .R0_addr(b_r_addr), .R0_data(b_data), .R0_valid(b_valid),
      .W0_en(b_w_en), .W0_addr(b_w_addr), .W0_data(b_w_data), .W0_mask(b_w_mask));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: entries as plain words, a countdown for the clear, and the last read result
   logic [31:0] mm [8];
   int cnt = 8;
   bit m_on = 0;
   logic m_ready = 0, m_valid = 0;
   logic [31:0] m_data = 0;
   always @(posedge clock) begin
      logic [31:0] bm, old;
      bm = 0;
      for (int i = 0; i < 4; i++) if (w_mask[i]) bm[i*8 +: 8] = 8'hFF;
      if (!reset_n) begin
         m_on = 1;
         cnt = 8;
         for (int i = 0; i < 8; i++) mm[i] = 0;
         m_data = 0;
         m_valid = 0;
      end else if (m_on) begin
         m_valid = (cnt == 0) && r_en;
         if (m_valid) begin
            old = mm[r_addr];
`ifdef SRAM_BYPASS_EN
            if (w_en && w_addr == r_addr) old = (old & ~bm) | (w_data & bm);
`endif
            m_data = old;
         end
         if (cnt == 0 && w_en) mm[w_addr] = (mm[w_addr] & ~bm) | (w_data & bm);
         if (cnt > 0) cnt--;
      end
      m_ready = m_on && cnt == 0;
   end

   always @(negedge clock) begin
      if (m_on) begin
         check("ready", {31'b0, ready}, {31'b0, m_ready});
         check("r0_valid", {31'b0, valid}, {31'b0, m_valid});
         check("r0_data", data, m_data);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic op(input logic re, input logic [2:0] ra, input logic we, input logic [2:0] wa,
                     input logic [31:0] wd, input logic [3:0] wm);
      r_en = re; r_addr = ra; w_en = we; w_addr = wa; w_data = wd; w_mask = wm;
      step();
      r_en = 0; w_en = 0;
   endtask

   task automatic wait_ready(output int n);
      n = 40;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (ready) begin
            n = k;
            break;
         end
      end
   endtask

   int n;
   initial begin
      step(); step();
      // Requests during the clear must be dropped
      r_en = 1; r_addr = 1; w_en = 1; w_addr = 1; w_data = 32'hAA; w_mask = 4'hF;
      reset_n = 1;
      wait_ready(n);
      check("clear_cycles", n, 8);
      r_en = 0; w_en = 0;
      for (int a = 0; a < 8; a++) begin
         op(1, 3'(a), 0, 0, 0, 0);
         check("clear_read", data, 0);
         check("clear_valid", {31'b0, valid}, 1);
      end
      step();
      check("valid_drop", {31'b0, valid}, 0);
      op(0, 0, 1, 3, 32'hFFFFFFFF, 4'hF);
      op(0, 0, 1, 3, 32'h12345678, 4'b0101);
      op(1, 3, 0, 0, 0, 0);
      check("mask_merge", data, 32'hFF34FF78);
      op(0, 0, 1, 5, 32'h11111111, 4'hF);
      op(1, 5, 1, 5, 32'h22222222, 4'b0011);
`ifdef SRAM_BYPASS_EN
      check("same_addr", data, 32'h11112222);
`else
      check("same_addr", data, 32'h11111111);
`endif
      op(1, 5, 0, 0, 0, 0);
      check("after_write", data, 32'h11112222);
      op(0, 0, 1, 2, 32'h7, 4'hF);
      op(1, 2, 0, 0, 0, 0);
      check("hold_read", data, 32'h7);
      op(0, 0, 1, 2, 32'h9, 4'hF);
      step();
      check("hold_data", data, 32'h7);
      check("hold_valid", {31'b0, valid}, 0);
      // Reset again, interrupt the clear at index 4, and time the restarted clear
      reset_n = 0; step(); reset_n = 1;
      for (int k = 0; k < 4; k++) step();
      check("midclear_ready", {31'b0, ready}, 0);
      reset_n = 0; step();
      check("midclear_data", data, 0);
      reset_n = 1;
      wait_ready(n);
      check("restart_cycles", n, 8);
      op(1, 2, 0, 0, 0, 0);
      check("cleared_again", data, 0);
      for (int k = 0; k < 400; k++) begin
         r_en = 1'($urandom); r_addr = 3'($urandom); w_en = 1'($urandom);
         w_addr = 3'($urandom); w_data = $urandom; w_mask = 4'($urandom);
         if (k % 5 == 0) w_addr = r_addr;
         step();
      end
      r_en = 0; w_en = 0;
      // Non-power-of-2 depth: out-of-range writes ignored, reads return 0 with a strobe
      step();
      b_rst_n = 1;
      n = 40;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (b_ready) begin
            n = k;
            break;
         end
      end
      check("d6_clear_cycles", n, 6);
      b_w_en = 1; b_w_addr = 5; b_w_data = 8'h5A; step();
      b_w_addr = 6; b_w_data = 8'h77; step();
      b_w_addr = 7; b_w_data = 8'h33; step();
      b_w_en = 0;
      b_r_en = 1; b_r_addr = 5; step();
      check("d6_read5", {24'b0, b_data}, 32'h5A);
      b_r_addr = 6; step();
      check("d6_read6", {24'b0, b_data}, 0);
      check("d6_valid6", {31'b0, b_valid}, 1);
      b_r_addr = 7; step();
      check("d6_read7", {24'b0, b_data}, 0);
      b_r_addr = 0; step();
      check("d6_read0", {24'b0, b_data}, 0);
      b_r_en = 0; step();
      check("d6_valid_off", {31'b0, b_valid}, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
